vproc_vreg_rd_sched: RTL and testbench
======================================

// Module: vproc_vreg_rd_sched
// PURPOSE
//  Schedules multi-beat vector-register read bursts from REQ_N units onto the PORTS_RD read ports of the vector register file.
//  Each request names a register group; the block drives one regfile address per port per cycle and streams registered data back.
//  Requests are round-robin arbitrated; a port is locked to its owner for the whole burst.
//  Sits between the execution units (ALU, MUL, LSU, ...) and the regfile read side.
// PARAMETERS
//  VREG_W    128  vector register width in bits
//  PORT_W     32  regfile port width in bits; BEATS = VREG_W/PORT_W beats per register
//  PORTS_RD    2  regfile read ports managed
//  REQ_N       4  requesting units
//  ADDR_W  = 5+$clog2(BEATS), derived (localparam); regfile address width
// PORTS
//  clk_i        in   1                 clock
//  async_rst_i  in   1                 asynchronous reset, active-high
//  flush_i      in   1                 abort all bursts (synchronous)
//  req_valid_i  in   REQ_N             request valid per unit
//  req_ready_o  out  REQ_N             request accepted this cycle
//  req_vreg_i   in   REQ_N x 5         base vector register
//  req_emul_i   in   REQ_N x 2         log2 group size (0:1, 1:2, 2:4, 3:8 regs)
//  rf_rd_addr_o out  PORTS_RD x ADDR_W regfile read address; the regfile read is combinational
//  rf_rd_data_i in   PORTS_RD x PORT_W regfile read data
//  rsp_valid_o  out  REQ_N             response beat valid
//  rsp_last_o   out  REQ_N             final beat of burst
//  rsp_data_o   out  REQ_N x PORT_W    response beat data
// BEHAVIOUR
//  Reset:
//   - All ports IDLE; rr_q=0; rsp_valid_o=0; rsp_last_o=0; rf_rd_addr_o=0.
//   - req_ready_o=0 while async_rst_i is high.
//   - Bursts in flight when reset asserts are dropped, with no further beats.
//  Per-port FSM, IDLE/BUSY:
//   - IDLE->BUSY on accept: load owner, addr_q={vreg,'0}, cnt_q=(1<<emul)*BEATS-1.
//   - BUSY: drive rf_rd_addr_o=addr_q, then addr_q++ and cnt_q--. Exit when cnt_q==0 (last beat).
//   - At the last beat the port may accept a new burst; otherwise it returns to IDLE.
//   - IDLE drives address 0.
//  Address arithmetic: addr_q increments modulo 2^ADDR_W (v31 wraps to v0); group alignment is not checked.
//  Arbitration (combinational, per cycle):
//   - Eligible unit: req_valid_i high and no burst in flight, or its burst is at its last beat.
//   - Available port: IDLE, or BUSY at its last beat.
//   - Scan units from rr_q upward (mod REQ_N). Each eligible unit gets the lowest-index available port until ports run out.
//   - req_ready_o[i] is high in exactly the cycle unit i is granted; it may depend on req_valid_i.
//   - Units must not make req_valid_i depend on req_ready_o; a held request must keep stable payload.
//   - rr_q <= (last granted unit + 1) mod REQ_N if any grant occurred, else unchanged.
//  Latency:
//   - Accept at edge T; beat k is addressed in cycle T+1+k.
//   - rsp_valid_o goes high in cycles T+2 .. T+1+N, where N = (1<<emul)*BEATS; rsp_last_o is high on the final beat.
//  Responses:
//   - rsp_data_o[owner] <= rf_rd_data_i[port] on every driven beat. No backpressure: units must accept every beat.
//   - Back-to-back bursts for one unit are gapless (new first beat directly follows old last beat).
//   - rsp_data_o is don't-care while rsp_valid_o is low.
//  flush_i:
//   - In the flush cycle: all ports go to IDLE next edge; req_ready_o=0.
//   - Beats whose address was driven before the flush cycle still return.
//   - No beat is addressed in or after the flush cycle; rr_q is unchanged.
//  Invariant: a unit never owns more than one port in BUSY at a non-last beat.
// STRUCTURE
//  vproc_pkg: typedef vreg_emul_e (EMUL1/2/4/8) for req_emul_i.
//  Sub-module vproc_vreg_rd_port_seq, one instance per port:
//   - Contains the FSM, addr_q/cnt_q, owner and last-beat flag.
//   - The top holds the arbiter, rr_q and the response mux/registers.
// TESTING
//  1. Single request, unit0, v3, emul=0, BEATS=4 -> addresses 12,13,14,15 in T+1..T+4; rsp T+2..T+5; last at T+5.
//  2. All 4 units valid, rr_q=0, 2 ports -> units 0,1 granted (ports 0,1); rr_q=2. Next free ports go to units 2,3.
//  3. Unit1 with a held request, re-requesting at its last beat -> regranted at last beat; 8 contiguous rsp beats, no gap.
//  4. emul=3, v28 -> 32 addresses 112..127, then 0..15 (wrap); rsp_last only on beat 32.
//  5. flush_i at beat 2 of a 4-beat burst -> beats 0,1 returned, no beat 2/3, port IDLE next cycle, ready=0 in flush cycle.
//  6. async_rst_i pulsed mid-burst (between edges) -> rsp_valid_o=0 and rf_rd_addr_o=0 immediately; fresh request after release behaves as test 1.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared types for the vector register read scheduler: register-group size
// encoding and the burst length helper used when a port loads a new burst.
package vproc_pkg;

   typedef enum logic [1:0] {
      EMUL1 = 2'd0,
      EMUL2 = 2'd1,
      EMUL4 = 2'd2,
      EMUL8 = 2'd3
   } vreg_emul_e;

   // Beats in a register group minus one: the burst counter's load value.
   function automatic int unsigned burst_len_m1(vreg_emul_e emul, int unsigned beats);
      return ((32'd1 << emul) * beats) - 32'd1;
   endfunction

endpackage

// File: rtl/vproc_vreg_rd_port_seq.sv
// One regfile read port: walks a register group one address per cycle, starting
// the cycle after accept; may take a new burst at its last beat, no stalls.
module vproc_vreg_rd_port_seq
   import vproc_pkg::*;
#(
   parameter int BEATS  = 4,
   parameter int ADDR_W = 7,
   parameter int UNIT_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              accept,
   input  logic [UNIT_W-1:0] new_owner,
   input  logic [4:0]        new_vreg,
   input  vreg_emul_e        new_emul,
   output logic [UNIT_W-1:0] owner,
   output logic              busy,
   output logic              last,
   output logic              avail,
   output logic              drive,
   output logic [ADDR_W-1:0] rd_addr
);

   localparam int CNT_W = $clog2(8 * BEATS);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [UNIT_W-1:0]  owner_q, owner_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      if (flush) begin
         state_d = IDLE;
      end else if (accept) begin
         state_d = BUSY;
         owner_d = new_owner;
         addr_d  = ADDR_W'(new_vreg) << $clog2(BEATS);
         cnt_d   = CNT_W'(burst_len_m1(new_emul, BEATS));
      end else if (state_q == BUSY) begin
         if (cnt_q == '0) begin
            state_d = IDLE;
         end else begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - CNT_W'(1);
         end
      end
   end

   // A flush cycle addresses nothing, so its beat never reaches a unit.
   assign busy    = (state_q == BUSY);
   assign last    = busy && (cnt_q == '0);
   assign avail   = !busy || last;
   assign drive   = busy && !flush;
   assign owner   = owner_q;
   assign rd_addr = drive ? addr_q : '0;

endmodule

// File: rtl/vproc_vreg_rd_sched.sv
// Round-robin scheduler of multi-beat vreg read bursts onto regfile read ports;
// data returns one cycle after its address, no response backpressure.
module vproc_vreg_rd_sched
   import vproc_pkg::*;
#(
   parameter  int VREG_W   = 128,
   parameter  int PORT_W   = 32,
   parameter  int PORTS_RD = 2,
   parameter  int REQ_N    = 4,
   localparam int BEATS    = VREG_W / PORT_W,
   localparam int ADDR_W   = 5 + $clog2(BEATS)
) (
   input  logic                               clk_i,
   input  logic                               async_rst_i,
   input  logic                               flush_i,
   input  logic [REQ_N-1:0]                   req_valid_i,
   output logic [REQ_N-1:0]                   req_ready_o,
   input  logic [REQ_N-1:0][4:0]              req_vreg_i,
   input  logic [REQ_N-1:0][1:0]              req_emul_i,
   output logic [PORTS_RD-1:0][ADDR_W-1:0]    rf_rd_addr_o,
   input  logic [PORTS_RD-1:0][PORT_W-1:0]    rf_rd_data_i,
   output logic [REQ_N-1:0]                   rsp_valid_o,
   output logic [REQ_N-1:0]                   rsp_last_o,
   output logic [REQ_N-1:0][PORT_W-1:0]       rsp_data_o
);

   localparam int UNIT_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

   logic [PORTS_RD-1:0]               p_busy, p_last, p_avail, p_drive, p_accept;
   logic [PORTS_RD-1:0][UNIT_W-1:0]   p_owner, p_new_owner;
   logic [PORTS_RD-1:0][4:0]          p_vreg;
   vreg_emul_e [PORTS_RD-1:0]         p_emul;

   logic [REQ_N-1:0]                  locked, ready;
   logic [PORTS_RD-1:0]               free;
   logic [UNIT_W-1:0]                 rr_q, rr_d, unit;
   logic                              placed;

   logic [REQ_N-1:0]                  rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d;
   logic [REQ_N-1:0][PORT_W-1:0]      rsp_data_q, rsp_data_d;

   for (genvar p = 0; p < PORTS_RD; p++) begin : g_port
      vproc_vreg_rd_port_seq #(
         .BEATS  (BEATS),
         .ADDR_W (ADDR_W),
         .UNIT_W (UNIT_W)
      ) u_seq (
         .clk       (clk_i),
         .rst       (async_rst_i),
         .flush     (flush_i),
         .accept    (p_accept[p]),
         .new_owner (p_new_owner[p]),
         .new_vreg  (p_vreg[p]),
         .new_emul  (p_emul[p]),
         .owner     (p_owner[p]),
         .busy      (p_busy[p]),
         .last      (p_last[p]),
         .avail     (p_avail[p]),
         .drive     (p_drive[p]),
         .rd_addr   (rf_rd_addr_o[p])
      );
   end

   // A unit mid-burst may not ask again until its burst reaches the last beat.
   always_comb begin
      locked = '0;
      for (int p = 0; p < PORTS_RD; p++) begin
         if (p_busy[p] && !p_last[p]) locked[p_owner[p]] = 1'b1;
      end
   end

   always_comb begin
      free        = p_avail;
      ready       = '0;
      p_accept    = '0;
      p_new_owner = '0;
      p_vreg      = '0;
      p_emul      = {PORTS_RD{EMUL1}};
      rr_d        = rr_q;
      unit        = '0;
      placed      = 1'b0;
      if (!flush_i && !async_rst_i) begin
         for (int i = 0; i < REQ_N; i++) begin
            unit   = UNIT_W'((int'(rr_q) + i) % REQ_N);
            placed = 1'b0;
            if (req_valid_i[unit] && !locked[unit]) begin
               for (int p = 0; p < PORTS_RD; p++) begin
                  if (!placed && free[p]) begin
                     placed         = 1'b1;
                     free[p]        = 1'b0;
                     p_accept[p]    = 1'b1;
                     p_new_owner[p] = unit;
                     p_vreg[p]      = req_vreg_i[unit];
                     p_emul[p]      = vreg_emul_e'(req_emul_i[unit]);
                     ready[unit]    = 1'b1;
                     rr_d           = UNIT_W'((int'(unit) + 1) % REQ_N);
                  end
               end
            end
         end
      end
   end

   assign req_ready_o = ready;

   // At most one port drives for a given unit in any cycle, so the mux never collides.
   always_comb begin
      rsp_valid_d = '0;
      rsp_last_d  = '0;
      rsp_data_d  = rsp_data_q;
      for (int p = 0; p < PORTS_RD; p++) begin
         if (p_drive[p]) begin
            rsp_valid_d[p_owner[p]] = 1'b1;
            rsp_last_d[p_owner[p]]  = p_last[p];
            rsp_data_d[p_owner[p]]  = rf_rd_data_i[p];
         end
      end
   end

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         rr_q        <= '0;
         rsp_valid_q <= '0;
         rsp_last_q  <= '0;
         rsp_data_q  <= '0;
      end else begin
         rr_q        <= rr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_last_o  = rsp_last_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_vproc_vreg_rd_sched.sv
// Bench for the vreg read scheduler: directed bursts from a table, corner
// sequences (arbitration, regrant, flush, async reset) and a random run vs a model.
module tb_vproc_vreg_rd_sched;

   localparam int RN    = 4;
   localparam int PR    = 2;
   localparam int BEATS = 4;
   localparam int AW    = 7;
   localparam int AS    = 128;

   logic                   clk, rst, flush;
   logic [RN-1:0]          req_valid, req_ready;
   logic [RN-1:0][4:0]     req_vreg;
   logic [RN-1:0][1:0]     req_emul;
   logic [PR-1:0][AW-1:0]  rf_addr;
   logic [PR-1:0][31:0]    rf_data;
   logic [RN-1:0]          rsp_valid, rsp_last;
   logic [RN-1:0][31:0]    rsp_data;

   int total, bad;

   vproc_vreg_rd_sched dut (
      .clk_i        (clk),
      .async_rst_i  (rst),
      .flush_i      (flush),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_vreg_i   (req_vreg),
      .req_emul_i   (req_emul),
      .rf_rd_addr_o (rf_addr),
      .rf_rd_data_i (rf_data),
      .rsp_valid_o  (rsp_valid),
      .rsp_last_o   (rsp_last),
      .rsp_data_o   (rsp_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] hash(input int a, input int p);
      return 32'(a * 257 + p * 32'h0100_0000 + 32'h5A5);
   endfunction

   // Combinational regfile: content is a fixed function of address and port.
   always_comb begin
      for (int p = 0; p < PR; p++) rf_data[p] = hash(int'(rf_addr[p]), p);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Single burst from an idle scheduler; lands on port 0.
   task automatic run_burst(input int u, input int vreg, input int emul, input int first, input int n);
      @(negedge clk);
      req_valid = '0;
      req_valid[u] = 1'b1;
      req_vreg[u] = 5'(vreg);
      req_emul[u] = 2'(emul);
      #1 chk("tbl_ready", 64'(req_ready), 64'(1 << u));
      @(negedge clk);
      req_valid = '0;
      for (int k = 0; k <= n + 1; k++) begin
         #1;
         chk("tbl_addr0", 64'(rf_addr[0]), 64'(k < n ? (first + k) % AS : 0));
         chk("tbl_addr1", 64'(rf_addr[1]), 64'(0));
         chk("tbl_rsp_valid", 64'(rsp_valid), 64'((k >= 1 && k <= n) ? (1 << u) : 0));
         if (k >= 1 && k <= n) begin
            chk("tbl_rsp_last", 64'(rsp_last), 64'(k == n ? (1 << u) : 0));
            chk("tbl_rsp_data", 64'(rsp_data[u]), 64'(hash((first + k - 1) % AS, 0)));
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      int unit;
      int vreg;
      int emul;
      int first;
      int beats;
   } vec_t;
   vec_t tbl[5];

   // Reference model: ports as {owner, base address, beat index, length}.
   bit          mb[PR];
   int          mo[PR], mbase[PR], mk[PR], mn[PR];
   int          mrr;
   bit          mrv[RN], mrl[RN];
   logic [31:0] mrd[RN];
   logic [RN-1:0] mg;

   task automatic model_cycle();
      bit avl[PR];
      bit lck[RN];
      int gown[PR];
      int lastg, u, a;
      bit took;
      logic [RN-1:0] g;
      for (int p = 0; p < PR; p++) begin
         avl[p] = !mb[p] || (mk[p] == mn[p] - 1);
         gown[p] = -1;
      end
      for (int i = 0; i < RN; i++) lck[i] = 1'b0;
      for (int p = 0; p < PR; p++) if (mb[p] && mk[p] != mn[p] - 1) lck[mo[p]] = 1'b1;
      g = '0;
      lastg = -1;
      if (!flush) begin
         for (int i = 0; i < RN; i++) begin
            u = (mrr + i) % RN;
            took = 1'b0;
            if (req_valid[u] && !lck[u]) begin
               for (int p = 0; p < PR; p++) begin
                  if (!took && avl[p]) begin
                     took = 1'b1;
                     avl[p] = 1'b0;
                     gown[p] = u;
                     g[u] = 1'b1;
                     lastg = u;
                  end
               end
            end
         end
      end
      chk("rnd_ready", 64'(req_ready), 64'(g));
      for (int p = 0; p < PR; p++) begin
         a = (mb[p] && !flush) ? (mbase[p] + mk[p]) % AS : 0;
         chk("rnd_addr", 64'(rf_addr[p]), 64'(a));
      end
      for (int i = 0; i < RN; i++) begin
         chk("rnd_rsp_valid", 64'(rsp_valid[i]), 64'(mrv[i]));
         if (mrv[i]) begin
            chk("rnd_rsp_last", 64'(rsp_last[i]), 64'(mrl[i]));
            chk("rnd_rsp_data", 64'(rsp_data[i]), 64'(mrd[i]));
         end
      end
      for (int i = 0; i < RN; i++) mrv[i] = 1'b0;
      for (int p = 0; p < PR; p++) begin
         if (mb[p] && !flush) begin
            a = (mbase[p] + mk[p]) % AS;
            mrv[mo[p]] = 1'b1;
            mrl[mo[p]] = (mk[p] == mn[p] - 1);
            mrd[mo[p]] = hash(a, p);
         end
      end
      for (int p = 0; p < PR; p++) begin
         if (flush) begin
            mb[p] = 1'b0;
         end else if (gown[p] >= 0) begin
            mb[p] = 1'b1;
            mo[p] = gown[p];
            mbase[p] = int'(req_vreg[gown[p]]) * BEATS;
            mk[p] = 0;
            mn[p] = (1 << int'(req_emul[gown[p]])) * BEATS;
         end else if (mb[p]) begin
            if (mk[p] == mn[p] - 1) mb[p] = 1'b0;
            else mk[p]++;
         end
      end
      if (lastg >= 0) mrr = (lastg + 1) % RN;
      mg = g;
   endtask

   task automatic new_req(input int u);
      req_valid[u] = 1'b1;
      req_vreg[u] = 5'($urandom_range(31, 0));
      req_emul[u] = ($urandom_range(7, 0) < 6) ? 2'($urandom_range(1, 0)) : 2'($urandom_range(3, 0));
   endtask

   initial begin
      total = 0;
      bad = 0;
      tbl[0] = '{0, 3, 0, 12, 4};
      tbl[1] = '{1, 5, 1, 20, 8};
      tbl[2] = '{2, 31, 1, 124, 8};
      tbl[3] = '{3, 28, 3, 112, 32};
      tbl[4] = '{1, 0, 2, 0, 16};

      // Reset state, with requests pending to show ready is held low.
      rst = 1'b1;
      flush = 1'b0;
      req_valid = '1;
      req_vreg = '0;
      req_emul = '0;
      #7;
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_last", 64'(rsp_last), 64'(0));
      chk("rst_addr", 64'(rf_addr), 64'(0));
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // Two ports, four requesters: 0,1 first, then rr_q=2 lets 2,3 beat 0,1.
      do_reset();
      @(negedge clk);
      for (int u = 0; u < RN; u++) begin
         req_vreg[u] = 5'(u + 1);
         req_emul[u] = 2'd0;
      end
      req_valid = 4'b1111;
      #1 chk("arb_first_grant", 64'(req_ready), 64'(4'b0011));
      @(negedge clk);
      req_valid = 4'b1100;
      #1;
      chk("arb_port0_addr", 64'(rf_addr[0]), 64'(4));
      chk("arb_port1_addr", 64'(rf_addr[1]), 64'(8));
      chk("arb_full_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      @(negedge clk);
      #1 chk("arb_busy_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      chk("arb_last_addr", 64'(rf_addr[0]), 64'(7));
      chk("arb_rr_grant", 64'(req_ready), 64'(4'b1100));
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("arb_u2_port0", 64'(rf_addr[0]), 64'(12));
      chk("arb_u3_port1", 64'(rf_addr[1]), 64'(16));
      repeat (6) @(negedge clk);

      for (int t = 0; t < 5; t++) run_burst(tbl[t].unit, tbl[t].vreg, tbl[t].emul, tbl[t].first, tbl[t].beats);

      // Held request regranted at the last beat: eight gapless beats.
      @(negedge clk);
      req_valid = 4'b0010;
      req_vreg[1] = 5'd5;
      req_emul[1] = 2'd0;
      #1 chk("b2b_grant", 64'(req_ready), 64'(4'b0010));
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         if (k == 0) req_vreg[1] = 5'd6;
         if (k == 4) req_valid = '0;
         #1;
         if (k <= 3) chk("b2b_ready", 64'(req_ready), 64'(k == 3 ? 4'b0010 : 4'b0000));
         chk("b2b_rsp_valid", 64'(rsp_valid), 64'((k >= 1 && k <= 8) ? 4'b0010 : 4'b0000));
         if (k >= 1 && k <= 8) begin
            chk("b2b_rsp_last", 64'(rsp_last), 64'((k == 4 || k == 8) ? 4'b0010 : 4'b0000));
            chk("b2b_rsp_data", 64'(rsp_data[1]), 64'(hash(19 + k, 0)));
         end
      end
      repeat (3) @(negedge clk);

      // Flush at beat 2 of a 4-beat burst.
      @(negedge clk);
      req_valid = 4'b0001;
      req_vreg[0] = 5'd3;
      req_emul[0] = 2'd0;
      #1 chk("fl_grant", 64'(req_ready), 64'(4'b0001));
      @(negedge clk);
      req_valid = '0;
      #1 chk("fl_beat0_addr", 64'(rf_addr[0]), 64'(12));
      @(negedge clk);
      #1;
      chk("fl_beat1_addr", 64'(rf_addr[0]), 64'(13));
      chk("fl_rsp0", 64'(rsp_data[0]), 64'(hash(12, 0)));
      @(negedge clk);
      flush = 1'b1;
      req_valid = 4'b0100;
      req_vreg[2] = 5'd9;
      req_emul[2] = 2'd0;
      #1;
      chk("fl_ready", 64'(req_ready), 64'(0));
      chk("fl_addr", 64'(rf_addr), 64'(0));
      chk("fl_rsp1_valid", 64'(rsp_valid), 64'(4'b0001));
      chk("fl_rsp1_data", 64'(rsp_data[0]), 64'(hash(13, 0)));
      @(negedge clk);
      flush = 1'b0;
      req_valid = 4'b0001;
      req_vreg[0] = 5'd7;
      #1;
      chk("fl_idle_addr", 64'(rf_addr[0]), 64'(0));
      chk("fl_no_beat2", 64'(rsp_valid), 64'(0));
      chk("fl_regrant", 64'(req_ready), 64'(4'b0001));
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("fl_new_addr", 64'(rf_addr[0]), 64'(28));
      chk("fl_no_beat3", 64'(rsp_valid), 64'(0));
      repeat (6) @(negedge clk);

      // Async reset pulse between edges, mid-burst.
      @(negedge clk);
      req_valid = 4'b0001;
      req_vreg[0] = 5'd3;
      req_emul[0] = 2'd0;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      req_valid = 4'b0100;
      #1;
      chk("ar_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("ar_addr", 64'(rf_addr), 64'(0));
      chk("ar_ready", 64'(req_ready), 64'(0));
      req_valid = '0;
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("ar_dropped_rsp", 64'(rsp_valid), 64'(0));
         chk("ar_dropped_addr", 64'(rf_addr), 64'(0));
      end
      run_burst(0, 3, 0, 12, 4);

      // Random traffic against the model.
      do_reset();
      for (int p = 0; p < PR; p++) mb[p] = 1'b0;
      for (int i = 0; i < RN; i++) mrv[i] = 1'b0;
      mrr = 0;
      mg = '0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         for (int u = 0; u < RN; u++) begin
            if (req_valid[u] && mg[u]) begin
               if ($urandom_range(1, 0) == 1) new_req(u);
               else req_valid[u] = 1'b0;
            end else if (!req_valid[u] && $urandom_range(3, 0) == 0) begin
               new_req(u);
            end
         end
         flush = ($urandom_range(39, 0) == 0);
         #1 model_cycle();
      end
      flush = 1'b0;
      req_valid = '0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
